memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles an access waits for mem_ack before it is faulted.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 valid_in  in  1  upstream execute stage presents a valid instruction.
REQ-005 bundle_in  in  7  control from execute: [6] mem_read, [5] mem_write, [4:3] size (00 byte, 01 half, 10/11 word), [2] load_unsigned, [1] reg_write, [0] mem_to_reg.
REQ-006 pc_seq_in / alu_in / store_in  in  32 each  sequential PC, ALU result (address or value), store data.
REQ-007 stall_out  out  1  upstream must hold its outputs when high.
REQ-008 mem_req, mem_we  out  1 each; mem_addr, mem_wdata  out  32 each; mem_be  out  4: data-memory request.
REQ-009 mem_ack  in  1; mem_rdata  in  32: memory completion and read data.
REQ-010 valid_out  out  1; bundle_out  out  2 ([1] reg_write, [0] mem_to_reg); pc_seq_out, alu_out, mem_data_out  out  32 each; fault_out  out  1: writeback-facing results.

Function
REQ-011 States: IDLE, ACCESS, DONE; stage registers hold valid, bundle, pc_seq, alu, store data.
REQ-012 Stage registers capture inputs on every edge where stall_out=0; otherwise they hold.
REQ-013 stall_out=1 exactly when state=ACCESS, including the mem_ack cycle.
REQ-014 On capture of valid_in=1 with mem_read or mem_write set and an aligned address: next state ACCESS. On any other capture: next state IDLE.
REQ-015 Alignment: half requires addr[0]=0; word requires addr[1:0]=00; byte is always aligned. mem_read and mem_write both set is treated as a write.
REQ-016 In ACCESS: mem_req=1; mem_addr={alu[31:2],2'b00}; mem_we=mem_write; signals constant until ack or timeout.
REQ-017 mem_be: byte = 1 shifted left by addr[1:0]; half = 0011 or 1100 per addr[1]; word = 1111; 0000 when mem_req=0.
REQ-018 mem_wdata: byte data replicated to all four lanes; half data replicated to both halves; word data unchanged.
REQ-019 mem_ack in ACCESS: load register captures the selected lane of mem_rdata, zero-extended if load_unsigned else sign-extended (0 for stores); next state DONE.
REQ-020 Wait counter clears on entry to ACCESS and increments each ACCESS cycle without ack; when it reaches TIMEOUT_CYCLES-1 without ack: mem_req drops next cycle, load register=0, fault latched, next state DONE.
REQ-021 mem_ack outside ACCESS is ignored.
REQ-022 valid_out=1 when stage valid and state is IDLE or DONE; 0 during ACCESS.
REQ-023 fault_out=1 with valid_out for a misaligned access or a timeout; a faulted instruction drives bundle_out[1]=0 and issues no request.
REQ-024 pc_seq_out, alu_out, and bundle_out (no fault) are driven directly from stage registers; mem_data_out comes from the load register.
REQ-025 DONE lasts exactly one cycle; stall_out=0 there, so the next instruction is captured on that edge.

Reset
REQ-026 reset low asynchronously forces state=IDLE, all stage registers, load register, counter and fault flag to 0; all outputs 0 (mem_req=0, stall_out=0, valid_out=0).
REQ-027 Reset asserted mid-ACCESS aborts the request immediately; a mem_ack arriving after reset deassertion is ignored.

Verification
REQ-028 LW at alu=0x100, ack after 3 wait cycles, rdata=0xDEADBEEF -> mem_req high 4 cycles, mem_be=1111, stall 4 cycles, then valid_out with mem_data_out=0xDEADBEEF, bundle_out=11.
REQ-029 LB at 0x103, rdata=0x80000000 -> mem_be=1000, mem_data_out=0xFFFFFF80; same as LBU -> 0x00000080.
REQ-030 SH at 0x102, store=0x1234ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD.
REQ-031 LW at 0x101 -> no mem_req, no stall, valid_out=1 with fault_out=1 and bundle_out[1]=0 the cycle after capture.
REQ-032 LW with mem_ack held low, TIMEOUT_CYCLES=4 -> mem_req high 4 cycles, then fault_out=1, mem_data_out=0.
REQ-033 Reset pulsed during ACCESS -> mem_req and stall_out drop immediately; late ack ignored; back-to-back ALU ops then pass with one-cycle latency.

Source files
------------

// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
//   Pipeline memory-access stage between execute and writeback. Captures one
//   instruction per cycle from execute, and for aligned loads/stores holds the
//   pipeline (stall_out) while a single data-memory request is outstanding.
//   Misaligned accesses and accesses that see no mem_ack within TIMEOUT_CYCLES
//   complete with fault_out set and register write suppressed.
//
// Ports
//   clk, reset            clock, asynchronous active-low reset
//   valid_in, bundle_in   instruction valid and control from execute:
//                         [6] mem_read [5] mem_write [4:3] size
//                         [2] load_unsigned [1] reg_write [0] mem_to_reg
//   pc_seq_in, alu_in,    sequential PC, ALU result / address, store data
//   store_in
//   stall_out             execute must hold its outputs while high
//   mem_req, mem_we,      data-memory request (word address, byte enables,
//   mem_addr, mem_be,     lane-replicated write data)
//   mem_wdata
//   mem_ack, mem_rdata    memory completion and read data
//   valid_out, bundle_out writeback-facing results; bundle_out is
//   pc_seq_out, alu_out,  {reg_write, mem_to_reg}
//   mem_data_out,
//   fault_out
// -----------------------------------------------------------------------------
module memory_stage #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [6:0]  bundle_in,
   input  logic [31:0] pc_seq_in,
   input  logic [31:0] alu_in,
   input  logic [31:0] store_in,
   output logic        stall_out,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        valid_out,
   output logic [1:0]  bundle_out,
   output logic [31:0] pc_seq_out,
   output logic [31:0] alu_out,
   output logic [31:0] mem_data_out,
   output logic        fault_out
);

   localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      DONE   = 2'b10
   } state_t;

   state_t            state;
   logic              stage_valid;
   logic [6:0]        stage_bundle;
   logic [31:0]       stage_pc;
   logic [31:0]       stage_alu;
   logic [31:0]       stage_store;
   logic [31:0]       load_reg;
   logic [CNT_W-1:0]  wait_cnt;
   logic              fault;

   // ---------------------------------------------------------------------------
   // Decode of the incoming instruction (used only on capture edges)
   // ---------------------------------------------------------------------------
   logic in_mem_op;
   logic in_aligned;

   assign in_mem_op  = bundle_in[6] | bundle_in[5];
   assign in_aligned = (bundle_in[4:3] == 2'b00) ||
                       ((bundle_in[4:3] == 2'b01) && !alu_in[0]) ||
                       (bundle_in[4] && (alu_in[1:0] == 2'b00));

   // ---------------------------------------------------------------------------
   // Decode of the held instruction
   // ---------------------------------------------------------------------------
   logic       st_write;
   logic [1:0] st_size;
   logic       st_unsigned;
   logic [1:0] lane;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_value;

   // mem_read is not needed here: a read+write access behaves as a write.
   assign st_write    = stage_bundle[5];
   assign st_size     = stage_bundle[4:3];
   assign st_unsigned = stage_bundle[2];
   assign lane        = stage_alu[1:0];

   assign ld_byte = mem_rdata[{lane, 3'b000} +: 8];
   assign ld_half = mem_rdata[{lane[1], 4'b0000} +: 16];

   // NOTE: every signal assigned in an always_comb gets a default first, so no
   // path through the case leaves it unassigned and infers a latch.
   always_comb begin
      load_value = mem_rdata;
      case (st_size)
         2'b00:   load_value = st_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         2'b01:   load_value = st_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: load_value = mem_rdata;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Memory request outputs: quiet (all zero) whenever no request is active
   // ---------------------------------------------------------------------------
   assign stall_out = (state == ACCESS);
   assign mem_req   = stall_out;
   assign mem_we    = mem_req & st_write;
   assign mem_addr  = mem_req ? {stage_alu[31:2], 2'b00} : 32'b0;

   always_comb begin
      mem_be    = 4'b0000;
      mem_wdata = 32'b0;
      if (mem_req) begin
         case (st_size)
            2'b00: begin
               mem_be    = 4'b0001 << lane;
               mem_wdata = {4{stage_store[7:0]}};
            end
            2'b01: begin
               mem_be    = lane[1] ? 4'b1100 : 4'b0011;
               mem_wdata = {2{stage_store[15:0]}};
            end
            default: begin
               mem_be    = 4'b1111;
               mem_wdata = stage_store;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Writeback-facing outputs
   // ---------------------------------------------------------------------------
   assign valid_out    = stage_valid & (state != ACCESS);
   assign fault_out    = valid_out & fault;
   assign bundle_out   = {stage_bundle[1] & ~fault, stage_bundle[0]};
   assign pc_seq_out   = stage_pc;
   assign alu_out      = stage_alu;
   assign mem_data_out = load_reg;

   // ---------------------------------------------------------------------------
   // Stage registers and access FSM. Any non-ACCESS state is a capture edge,
   // so DONE hands over to the next instruction without a bubble.
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         stage_valid  <= 1'b0;
         stage_bundle <= '0;
         stage_pc     <= '0;
         stage_alu    <= '0;
         stage_store  <= '0;
         load_reg     <= '0;
         wait_cnt     <= '0;
         fault        <= 1'b0;
      end else begin
         case (state)
            ACCESS: begin
               if (mem_ack) begin
                  load_reg <= st_write ? 32'b0 : load_value;
                  state    <= DONE;
               end else if (wait_cnt == CNT_LAST) begin
                  load_reg <= '0;
                  fault    <= 1'b1;
                  state    <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            default: begin
               stage_valid  <= valid_in;
               stage_bundle <= bundle_in;
               stage_pc     <= pc_seq_in;
               stage_alu    <= alu_in;
               stage_store  <= store_in;
               load_reg     <= '0;
               wait_cnt     <= '0;
               if (valid_in && in_mem_op && in_aligned) begin
                  state <= ACCESS;
                  fault <= 1'b0;
               end else begin
                  // A misaligned access faults here and never reaches memory.
                  state <= IDLE;
                  fault <= valid_in & in_mem_op & ~in_aligned;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_stage
//   Scoreboard bench for memory_stage (TIMEOUT_CYCLES = 4). Each issued
//   instruction pushes its expected writeback result (and, for aligned memory
//   ops, its expected memory request) onto queues; a writeback monitor and a
//   memory responder pop and compare as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_memory_stage;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [6:0]  bundle_in;
   logic [31:0] pc_seq_in, alu_in, store_in;
   logic        stall_out, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        valid_out;
   logic [1:0]  bundle_out;
   logic [31:0] pc_seq_out, alu_out, mem_data_out;
   logic        fault_out;

   memory_stage #(.TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .valid_in     (valid_in),
      .bundle_in    (bundle_in),
      .pc_seq_in    (pc_seq_in),
      .alu_in       (alu_in),
      .store_in     (store_in),
      .stall_out    (stall_out),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_be       (mem_be),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .valid_out    (valid_out),
      .bundle_out   (bundle_out),
      .pc_seq_out   (pc_seq_out),
      .alu_out      (alu_out),
      .mem_data_out (mem_data_out),
      .fault_out    (fault_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Control bundles: {rd, wr, size[1:0], unsigned, reg_write, mem_to_reg}
   localparam logic [6:0] B_LW   = 7'b1010011;
   localparam logic [6:0] B_LH   = 7'b1001011;
   localparam logic [6:0] B_LB   = 7'b1000011;
   localparam logic [6:0] B_LBU  = 7'b1000111;
   localparam logic [6:0] B_SH   = 7'b0101000;
   localparam logic [6:0] B_SB   = 7'b0100000;
   localparam logic [6:0] B_RW   = 7'b1110011;
   localparam logic [6:0] B_ALU  = 7'b0000010;

   typedef struct {
      logic [1:0]  bundle;
      logic [31:0] pc;
      logic [31:0] alu;
      logic [31:0] data;
      logic        fault;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
      int          cycles;
   } req_t;

   exp_t exp_q[$];
   req_t req_q[$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Responder configuration, written by the driver only while no access is live
   int          resp_ack_after = -1;
   logic [31:0] resp_rdata     = '0;
   logic        late_ack_req   = 1'b0;
   logic        abort_pending  = 1'b0;

   // ---------------------------------------------------------------------------
   // Reference model of one instruction's result
   // ---------------------------------------------------------------------------
   function automatic logic [31:0] model_load(input logic [6:0] b, input logic [31:0] a,
                                              input logic [31:0] rd);
      logic [31:0] sh;
      sh = rd >> {a[1:0], 3'b000};
      case (b[4:3])
         2'b00:   return b[2] ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         2'b01:   return b[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: return rd;
      endcase
   endfunction

   task automatic issue(input logic v, input logic [6:0] b, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] st,
                        input int ack_after, input logic [31:0] rdata);
      int   guard;
      int   ncyc;
      int   lat;
      logic mem_op, wr, aligned, tmo;
      exp_t e;
      req_t r;
      guard = 0;
      @(negedge clk);
      while (stall_out && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) check("stall_bound", 32'(stall_out), 32'd0);
      valid_in       = v;
      bundle_in      = b;
      pc_seq_in      = pc;
      alu_in         = a;
      store_in       = st;
      resp_ack_after = ack_after;
      resp_rdata     = rdata;

      mem_op  = b[6] | b[5];
      wr      = b[5];
      aligned = (b[4:3] == 2'b00) || (b[4:3] == 2'b01 && a[0] == 1'b0) ||
                (b[4] && a[1:0] == 2'b00);
      if (v) begin
         e.pc = pc; e.alu = a; e.fault = 1'b0; e.data = '0; e.bundle = b[1:0];
         lat = 1;
         if (mem_op && !aligned) begin
            e.fault = 1'b1;
            e.bundle[1] = 1'b0;
         end else if (mem_op) begin
            tmo  = (ack_after < 0) || (ack_after >= TO);
            ncyc = tmo ? TO : ack_after + 1;
            lat  = 1 + ncyc;
            if (tmo) begin
               e.fault = 1'b1;
               e.bundle[1] = 1'b0;
            end else if (!wr) begin
               e.data = model_load(b, a, rdata);
            end
            r.addr   = {a[31:2], 2'b00};
            r.we     = wr;
            r.cycles = ncyc;
            case (b[4:3])
               2'b00:   begin r.be = 4'b0001 << a[1:0];          r.wdata = {4{st[7:0]}};  end
               2'b01:   begin r.be = a[1] ? 4'b1100 : 4'b0011;   r.wdata = {2{st[15:0]}}; end
               default: begin r.be = 4'b1111;                    r.wdata = st;            end
            endcase
            req_q.push_back(r);
         end
         e.cyc = cyc + lat;
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      valid_in = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Memory responder: acks after resp_ack_after wait cycles, checks request
   // ---------------------------------------------------------------------------
   initial begin
      logic        active, have_cur, changed;
      int          rcnt, scnt;
      req_t        cur;
      logic [31:0] f_addr, f_wdata;
      logic [3:0]  f_be;
      logic        f_we;
      active = 1'b0; have_cur = 1'b0; changed = 1'b0; rcnt = 0; scnt = 0;
      f_addr = '0; f_wdata = '0; f_be = '0; f_we = 1'b0;
      cur = '{addr: 32'b0, be: 4'b0, we: 1'b0, wdata: 32'b0, cycles: 0};
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (late_ack_req) begin
            mem_ack      = 1'b1;
            mem_rdata    = 32'h1111_2222;
            late_ack_req = 1'b0;
         end else if (mem_req) begin
            if (!active) begin
               active  = 1'b1;
               rcnt    = 0;
               scnt    = 0;
               changed = 1'b0;
               f_addr = mem_addr; f_wdata = mem_wdata; f_be = mem_be; f_we = mem_we;
               if (req_q.size() == 0) begin
                  check("unexpected_req", 32'(mem_req), 32'd0);
                  have_cur = 1'b0;
               end else begin
                  cur      = req_q.pop_front();
                  have_cur = 1'b1;
               end
            end else if (mem_addr !== f_addr || mem_wdata !== f_wdata ||
                         mem_be !== f_be || mem_we !== f_we) begin
               changed = 1'b1;
            end
            rcnt++;
            if (stall_out) scnt++;
            mem_ack   = (resp_ack_after >= 0) && (rcnt == resp_ack_after + 1);
            mem_rdata = resp_rdata;
         end else begin
            mem_ack = 1'b0;
            if (active) begin
               active = 1'b0;
               if (abort_pending) begin
                  abort_pending = 1'b0;
               end else if (have_cur) begin
                  check("req_addr",   f_addr,       cur.addr);
                  check("req_be",     32'(f_be),    32'(cur.be));
                  check("req_we",     32'(f_we),    32'(cur.we));
                  check("req_wdata",  f_wdata,      cur.wdata);
                  check("req_cycles", rcnt,         cur.cycles);
                  check("stall_cyc",  scnt,         cur.cycles);
                  check("req_stable", 32'(changed), 32'd0);
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Writeback monitor
   // ---------------------------------------------------------------------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && valid_out) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 32'(valid_out), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("wb_bundle",  32'(bundle_out), 32'(e.bundle));
               check("wb_pc",      pc_seq_out,      e.pc);
               check("wb_alu",     alu_out,         e.alu);
               check("wb_data",    mem_data_out,    e.data);
               check("wb_fault",   32'(fault_out),  32'(e.fault));
               check("wb_latency", cyc,             e.cyc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      reset     = 1'b0;
      valid_in  = 1'b0;
      bundle_in = '0;
      pc_seq_in = '0;
      alu_in    = '0;
      store_in  = '0;
      repeat (3) @(negedge clk);
      check("rst_mem_req",   32'(mem_req),      32'd0);
      check("rst_stall",     32'(stall_out),    32'd0);
      check("rst_valid",     32'(valid_out),    32'd0);
      check("rst_fault",     32'(fault_out),    32'd0);
      check("rst_be",        32'(mem_be),       32'd0);
      check("rst_addr",      mem_addr,          32'd0);
      check("rst_bundle",    32'(bundle_out),   32'd0);
      check("rst_data",      mem_data_out,      32'd0);
      check("rst_pc",        pc_seq_out,        32'd0);
      reset = 1'b1;

      issue(1'b1, B_LW,  32'h0000_1004, 32'h0000_0100, 32'h0,         3,  32'hDEAD_BEEF);
      issue(1'b1, B_LB,  32'h0000_1008, 32'h0000_0103, 32'h0,         1,  32'h8000_0000);
      issue(1'b1, B_LBU, 32'h0000_100C, 32'h0000_0103, 32'h0,         0,  32'h8000_0000);
      issue(1'b1, B_SH,  32'h0000_1010, 32'h0000_0102, 32'h1234_ABCD, 0,  32'h0);
      issue(1'b1, B_LW,  32'h0000_1014, 32'h0000_0101, 32'h0,         0,  32'h5555_5555);
      issue(1'b1, B_ALU, 32'h0000_1018, 32'h0000_0055, 32'h0,         0,  32'h0);
      issue(1'b1, B_LW,  32'h0000_101C, 32'h0000_0300, 32'h0,         -1, 32'h0);
      issue(1'b1, B_LW,  32'h0000_1020, 32'h0000_0304, 32'h0,         TO, 32'h7777_7777);
      issue(1'b1, B_LH,  32'h0000_1024, 32'h0000_0102, 32'h0,         2,  32'h8001_1234);
      issue(1'b1, B_SB,  32'h0000_1028, 32'h0000_0101, 32'h0000_00AB, 1,  32'h0);
      issue(1'b1, B_RW,  32'h0000_102C, 32'h0000_0200, 32'hCAFE_F00D, 0,  32'hFFFF_FFFF);
      issue(1'b1, B_LH,  32'h0000_1030, 32'h0000_0103, 32'h0,         0,  32'h0);
      issue(1'b0, B_LW,  32'h0000_1034, 32'h0000_0400, 32'h0,         0,  32'h0);
      issue(1'b1, B_ALU, 32'h0000_1038, 32'hA5A5_0001, 32'h0,         0,  32'h0);

      // Reset in the middle of an access, then a stray ack after release.
      issue(1'b1, B_LW,  32'h0000_2000, 32'h0000_0500, 32'h0,         -1, 32'h0);
      @(negedge clk);
      @(posedge clk);
      #2;
      abort_pending = 1'b1;
      void'(exp_q.pop_back());
      reset = 1'b0;
      #1;
      check("abort_mem_req", 32'(mem_req),   32'd0);
      check("abort_stall",   32'(stall_out), 32'd0);
      check("abort_valid",   32'(valid_out), 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset        = 1'b1;
      late_ack_req = 1'b1;
      repeat (3) @(negedge clk);
      check("late_ack_req",   32'(mem_req),      32'd0);
      check("late_ack_stall", 32'(stall_out),    32'd0);
      check("late_ack_valid", 32'(valid_out),    32'd0);
      check("late_ack_data",  mem_data_out,      32'd0);
      check("abort_seen",     32'(abort_pending), 32'd0);

      issue(1'b1, B_ALU, 32'h0000_3004, 32'h0000_0011, 32'h0, 0, 32'h0);
      issue(1'b1, B_ALU, 32'h0000_3008, 32'h0000_0022, 32'h0, 0, 32'h0);
      issue(1'b1, B_ALU, 32'h0000_300C, 32'h0000_0033, 32'h0, 0, 32'h0);

      repeat (8) @(negedge clk);
      check("exp_q_empty", exp_q.size(), 32'd0);
      check("req_q_empty", req_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
